// File: rtl/aes_pkg.sv
// Shared AES constants: forward S-box table and default state-matrix geometry.
// Pure constants, no logic; no latency or flow control applies.
// Imported by sbox and sbox_lut.
package aes_pkg;

    localparam int DEF_NO_ROWS = 4;
    localparam int DEF_NO_COLS = 4;

    // Indexed by the input byte; entry order follows the usual 16x16 layout (high nibble = row).
    localparam logic [7:0] SBOX_FWD [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

endpackage

// File: rtl/sbox_lut.sv
// Single-byte AES forward S-box lookup.
// Latency: combinational, zero cycles.
// Backpressure: none; output follows input.
module sbox_lut
    import aes_pkg::*;
(
    input  logic [7:0] lut_in,
    output logic [7:0] lut_out
);

    assign lut_out = SBOX_FWD[lut_in];

endmodule

// File: rtl/sbox.sv
// Masked AES SubBytes over a NO_ROWS x NO_COLS byte matrix; unmasked bytes pass through.
// Latency: 1 cycle from sbox_en sampled high to the registered result and valid.
// Backpressure: none; requester holds sbox_en until valid, result stays after valid drops.
module sbox
    import aes_pkg::*;
#(
    parameter int NO_ROWS = DEF_NO_ROWS,
    parameter int NO_COLS = DEF_NO_COLS
) (
    input  logic                                 aes_clk,
    input  logic                                 reset,
    input  logic                                 sbox_en,
    input  logic [NO_ROWS-1:0][NO_COLS-1:0][7:0] sbox_ip_char_matrix,
    input  logic [3:0]                           sbox_ip_char_row_mask,
    input  logic [3:0]                           sbox_ip_char_col_mask,
    output logic                                 sbox_op_char_matrix_valid,
    output logic [NO_ROWS-1:0][NO_COLS-1:0][7:0] sbox_op_char_matrix
);

    logic [NO_ROWS-1:0][NO_COLS-1:0][7:0] sub_dat;
    logic [NO_ROWS-1:0][NO_COLS-1:0][7:0] nxt_dat;

    // Loop bounds stop at NO_ROWS/NO_COLS, so mask bits beyond the matrix never matter.
    for (genvar r = 0; r < NO_ROWS; r++) begin : g_row
        for (genvar c = 0; c < NO_COLS; c++) begin : g_col
            sbox_lut u_lut (
                .lut_in  (sbox_ip_char_matrix[r][c]),
                .lut_out (sub_dat[r][c])
            );

            assign nxt_dat[r][c] = (sbox_ip_char_row_mask[r] && sbox_ip_char_col_mask[c])
                                 ? sub_dat[r][c] : sbox_ip_char_matrix[r][c];
        end
    end

    always_ff @(posedge aes_clk or posedge reset) begin
        if (reset) begin
            sbox_op_char_matrix       <= '0;
            sbox_op_char_matrix_valid <= 1'b0;
        end else begin
            sbox_op_char_matrix_valid <= sbox_en;
            if (sbox_en) begin
                sbox_op_char_matrix <= nxt_dat;
            end
        end
    end

endmodule

// File: tb/tb_sbox.sv
// Scoreboard bench for sbox: stimulus queues expected matrices, a monitor pops on valid.
module tb_sbox;

    localparam int R = 4;
    localparam int C = 4;
    typedef logic [R-1:0][C-1:0][7:0] mat_t;

    logic       aes_clk;
    logic       reset;
    logic       sbox_en;
    mat_t       sbox_ip_char_matrix;
    logic [3:0] sbox_ip_char_row_mask;
    logic [3:0] sbox_ip_char_col_mask;
    logic       sbox_op_char_matrix_valid;
    mat_t       sbox_op_char_matrix;

    int   checks = 0;
    int   errors = 0;
    mat_t exp_q[$];
    logic [7:0] inv_t [256];

    sbox #(.NO_ROWS(R), .NO_COLS(C)) dut (
        .aes_clk                   (aes_clk),
        .reset                     (reset),
        .sbox_en                   (sbox_en),
        .sbox_ip_char_matrix       (sbox_ip_char_matrix),
        .sbox_ip_char_row_mask     (sbox_ip_char_row_mask),
        .sbox_ip_char_col_mask     (sbox_ip_char_col_mask),
        .sbox_op_char_matrix_valid (sbox_op_char_matrix_valid),
        .sbox_op_char_matrix       (sbox_op_char_matrix)
    );

    initial aes_clk = 1'b0;
    always #5 aes_clk = ~aes_clk;

    // Independent reference: GF(2^8) inverse followed by the AES affine map.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int k = 0; k < 8; k++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] v, input int k);
        return (v << k) | (v >> (8 - k));
    endfunction

    function automatic logic [7:0] sbox_model(input logic [7:0] v);
        logic [7:0] iv = inv_t[v];
        return iv ^ rotl(iv, 1) ^ rotl(iv, 2) ^ rotl(iv, 3) ^ rotl(iv, 4) ^ 8'h63;
    endfunction

    task automatic check_val(input string name, input logic [127:0] act, input logic [127:0] req);
        checks = checks + 1;
        if (act !== req) begin
            errors = errors + 1;
            $display("FAIL %s got %h expected %h", name, act, req);
        end
    endtask

    task automatic issue(input mat_t m, input logic [3:0] rm, input logic [3:0] cm,
                         input logic en, input mat_t exp_m);
        @(negedge aes_clk);
        sbox_ip_char_matrix   = m;
        sbox_ip_char_row_mask = rm;
        sbox_ip_char_col_mask = cm;
        sbox_en               = en;
        if (en) exp_q.push_back(exp_m);
    endtask

    // Monitor: every valid output must match the oldest queued expectation.
    always @(posedge aes_clk) begin
        mat_t exp_m;
        #1;
        if (!reset && sbox_op_char_matrix_valid) begin
            checks = checks + 1;
            if (exp_q.size() == 0) begin
                errors = errors + 1;
                $display("FAIL unexpected_valid got %h expected no output", sbox_op_char_matrix);
            end else begin
                exp_m = exp_q.pop_front();
                if (sbox_op_char_matrix !== exp_m) begin
                    errors = errors + 1;
                    $display("FAIL scoreboard got %h expected %h", sbox_op_char_matrix, exp_m);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        mat_t m;
        mat_t e;
        mat_t held;

        for (int a = 0; a < 256; a++) inv_t[a] = 8'h00;
        for (int a = 1; a < 256; a++)
            for (int b = 1; b < 256; b++)
                if (gmul(8'(a), 8'(b)) == 8'h01) inv_t[a] = 8'(b);

        // Reset with a live request and nonzero data, before any clock edge.
        reset                 = 1'b1;
        sbox_en               = 1'b1;
        sbox_ip_char_matrix   = {16{8'hab}};
        sbox_ip_char_row_mask = 4'hf;
        sbox_ip_char_col_mask = 4'hf;
        #2;
        check_val("reset_data_async", sbox_op_char_matrix, '0);
        check_val("reset_valid_async", 128'(sbox_op_char_matrix_valid), 128'd0);
        repeat (3) @(negedge aes_clk);
        check_val("reset_data_held", sbox_op_char_matrix, '0);
        check_val("reset_valid_held", 128'(sbox_op_char_matrix_valid), 128'd0);
        sbox_en = 1'b0;
        reset   = 1'b0;

        // Full substitution, single-cycle request.
        m = '0;
        m[0][0] = 8'h19; m[0][1] = 8'ha0; m[0][2] = 8'h9a; m[0][3] = 8'he9;
        e = {16{8'h63}};
        e[0][0] = 8'hd4; e[0][1] = 8'he0; e[0][2] = 8'hb8; e[0][3] = 8'h1e;
        issue(m, 4'hf, 4'hf, 1'b1, e);
        held = e;
        issue({16{8'hff}}, 4'hf, 4'hf, 1'b0, '0);
        @(negedge aes_clk);
        check_val("full_valid_drop", 128'(sbox_op_char_matrix_valid), 128'd0);
        check_val("full_data_hold", sbox_op_char_matrix, held);

        // Single element selected by masks.
        e = '0;
        e[1][2] = 8'h63;
        issue('0, 4'b0010, 4'b0100, 1'b1, e);
        issue('0, 4'h0, 4'h0, 1'b0, '0);

        // Checkerboard-ish masks: rows 1,3 and cols 0,1.
        e = {16{8'h01}};
        e[1][0] = 8'h7c; e[1][1] = 8'h7c; e[3][0] = 8'h7c; e[3][1] = 8'h7c;
        issue({16{8'h01}}, 4'b1010, 4'b0011, 1'b1, e);
        issue('0, 4'h0, 4'h0, 1'b0, '0);

        // Zero masks pass data through and still raise valid.
        issue({16{8'h53}}, 4'h0, 4'h0, 1'b1, {16{8'h53}});
        issue('0, 4'h0, 4'h0, 1'b0, '0);

        // Streaming with sbox_en held high.
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) issue({16{8'h00}}, 4'hf, 4'hf, 1'b1, {16{8'h63}});
            else            issue({16{8'hff}}, 4'hf, 4'hf, 1'b1, {16{8'h16}});
        end

        // Every byte value through element [0][0].
        for (int i = 0; i < 256; i++) begin
            m = '0;
            m[0][0] = 8'(i);
            e = {16{8'h63}};
            e[0][0] = sbox_model(8'(i));
            issue(m, 4'hf, 4'hf, 1'b1, e);
        end
        issue('0, 4'h0, 4'h0, 1'b0, '0);
        @(negedge aes_clk);

        // Reset mid-request discards the pending result.
        issue({16{8'hff}}, 4'hf, 4'hf, 1'b1, {16{8'h16}});
        #1;
        reset = 1'b1;
        exp_q.delete();
        #1;
        check_val("midreset_data", sbox_op_char_matrix, '0);
        check_val("midreset_valid", 128'(sbox_op_char_matrix_valid), 128'd0);
        @(negedge aes_clk);
        check_val("midreset_data_edge", sbox_op_char_matrix, '0);
        sbox_en = 1'b0;
        reset   = 1'b0;
        @(negedge aes_clk);
        check_val("postreset_idle_valid", 128'(sbox_op_char_matrix_valid), 128'd0);
        issue('0, 4'hf, 4'hf, 1'b1, {16{8'h63}});
        issue('0, 4'h0, 4'h0, 1'b0, '0);

        repeat (3) @(negedge aes_clk);
        check_val("scoreboard_drained", 128'(exp_q.size()), 128'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sbox.md
SBOX -- requirements
Module: sbox

Interface
REQ-001 Parameter NO_ROWS, default 4: number of rows in the state matrix; legal range 1..4.
REQ-002 Parameter NO_COLS, default 4: number of columns in the state matrix; legal range 1..4.
REQ-003 aes_clk  input  1: the single clock; all state updates on its rising edge.
REQ-004 reset  input  1: reset, asynchronous, active-high.
REQ-005 sbox_en  input  1: substitution request, sampled every rising edge.
REQ-006 sbox_ip_char_matrix  input  8 x [NO_ROWS][NO_COLS]: input byte matrix, indexed [row][col].
REQ-007 sbox_ip_char_row_mask  input  4: bit r enables row r.
REQ-008 sbox_ip_char_col_mask  input  4: bit c enables column c.
REQ-009 sbox_op_char_matrix_valid  output  1: output matrix holds a result.
REQ-010 sbox_op_char_matrix  output  8 x [NO_ROWS][NO_COLS]: substituted byte matrix.

Function
REQ-011 Byte substitution SHALL use the AES forward S-box (FIPS-197 Fig. 7) exactly, e.g. 00->63, 01->7C, 53->ED, FF->16.
REQ-012 Element [r][c] SHALL be substituted only when row mask bit r AND column mask bit c are both 1; otherwise it SHALL pass through unchanged.
REQ-013 Mask bits at indices >= NO_ROWS (rows) or >= NO_COLS (columns) SHALL be ignored.
REQ-014 On each rising edge with sbox_en=1, sbox_op_char_matrix SHALL load the masked substitution of the current input matrix and masks; latency is exactly 1 cycle.
REQ-015 On each rising edge with sbox_en=0, sbox_op_char_matrix SHALL hold its previous value.
REQ-016 sbox_op_char_matrix_valid SHALL be the registered value of sbox_en: 1 the cycle after sbox_en is sampled 1, 0 the cycle after sbox_en is sampled 0.
REQ-017 While sbox_en stays 1, the output SHALL be recomputed every cycle, so input or mask changes appear one cycle later with valid held at 1.
REQ-018 With both masks all-zero and sbox_en=1, the output SHALL equal the input one cycle later, and valid SHALL still assert.
REQ-019 A requester SHALL hold sbox_en at 1 until valid is seen, then drop it; the block SHALL NOT require any other handshake, and the last result remains on the output after valid falls.
REQ-020 No state machine SHALL be used; the only state is the output matrix register and the valid flag.

Reset
REQ-021 While reset=1, sbox_op_char_matrix SHALL be all 0x00 and sbox_op_char_matrix_valid SHALL be 0, immediately and independent of aes_clk.
REQ-022 Reset asserted mid-operation SHALL discard any pending result; after release, valid SHALL first assert one cycle after sbox_en is sampled 1.

Structure
REQ-023 A shared package aes_pkg SHALL hold the 256-entry forward S-box constant table and the default NO_ROWS/NO_COLS constants.
REQ-024 One sub-module sbox_lut SHALL perform the combinational single-byte lookup; sbox SHALL instantiate it once per matrix element.

Verification
REQ-025 Reset: assert reset with sbox_en=1 and a nonzero input -> output all 0x00 and valid=0 with no clock edge; both stay so until reset falls.
REQ-026 Full substitution: input row0 = {19,A0,9A,E9}, masks F/F, sbox_en=1 for one edge -> next cycle row0 = {D4,E0,B8,1E}, valid=1; after sbox_en falls, valid=0 and data held.
REQ-027 Partial mask: all inputs 0x00, row mask 4'b0010, column mask 4'b0100 -> only [1][2]=63, all other elements 00.
REQ-028 Zero masks: input all 0x53, masks 0/0, sbox_en=1 -> output all 53, valid=1.
REQ-029 Streaming: sbox_en held 1 while input alternates all-00 / all-FF each cycle -> output alternates all-63 / all-16 one cycle later, and valid stays 1.
REQ-030 Exhaustive LUT: apply every byte 00..FF at element [0][0] -> each output matches the FIPS-197 table.
